syzygy_adc_word_align: RTL and testbench

Re-aligns the raw 8-bit per-lane ISERDES words of a 2-lane-per-channel SYZYGY ADC and assembles them into 16-bit samples. It sits directly downstream of the frame-alignment stage and consumes that stage's `data_valid` and `bitslip_count` outputs. Alignment uses a word-level barrel shift across consecutive words instead of primitive bitslip. When the frame stage changes its slip value, the block re-settles and resumes streaming.

---
 rtl/syzygy_adc_pkg.sv | 15 +
 rtl/syzygy_adc_lane_shift.sv | 39 +++
 rtl/syzygy_adc_word_align.sv | 109 ++++++++++
 tb/tb_syzygy_adc_word_align.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/syzygy_adc_pkg.sv
// Shared constants and state type for the SYZYGY ADC word-alignment block.
package syzygy_adc_pkg;

  localparam int unsigned LANE_WIDTH    = 8;
  localparam int unsigned SAMPLE_WIDTH  = 16;
  localparam int unsigned SLIP_MAX      = 7;
  localparam int unsigned SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    STREAM
  } align_state_e;

endpackage

// File: rtl/syzygy_adc_lane_shift.sv
// One ISERDES lane: two-word history and a word-level barrel shift.
module syzygy_adc_lane_shift
  import syzygy_adc_pkg::*;
(
  input  logic                  slow_clk,
  input  logic                  reset,
  input  logic [LANE_WIDTH-1:0] lane_in,
  input  logic [2:0]            slip,
  output logic [LANE_WIDTH-1:0] aligned
);

  logic [LANE_WIDTH-1:0]   curr_q, curr_d;
  logic [LANE_WIDTH-1:0]   prev_q, prev_d;
  logic [2*LANE_WIDTH-1:0] pair_shifted;

  // Word history advances every cycle, independent of alignment state.
  always_comb begin
    curr_d = lane_in;
    prev_d = curr_q;
  end

  // History registers.
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      curr_q <= '0;
      prev_q <= '0;
    end else begin
      curr_q <= curr_d;
      prev_q <= prev_d;
    end
  end

  // Select the aligned byte out of the concatenated word pair.
  always_comb begin
    pair_shifted = {prev_q, curr_q} >> slip;
    aligned      = pair_shifted[LANE_WIDTH-1:0];
  end

endmodule

// File: rtl/syzygy_adc_word_align.sv
// Word aligner: FSM tracking the frame stage's slip value, per-lane barrel
// shifters and registered 16-bit sample assembly.
module syzygy_adc_word_align
  import syzygy_adc_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2
) (
  input  logic                                 slow_clk,
  input  logic                                 reset,
  input  logic                                 frame_valid,
  input  logic [3:0]                           bitslip_count,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] lane_data,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_out,
  output logic                                 sample_valid,
  output logic                                 align_error,
  output logic [7:0]                           realign_count
);

  align_state_e                         state_q, state_d;
  logic [1:0]                           settle_cnt_q, settle_cnt_d;
  logic [2:0]                           slip_q, slip_d;
  logic                                 align_error_q, align_error_d;
  logic [7:0]                           realign_count_q, realign_count_d;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] aligned_all;
  logic                                 slip_legal;

  // Lane placement in lane_data matches byte placement in sample_out, so each
  // lane's aligned byte lands in the same bit slice it came from.
  for (genvar g = 0; g < 2 * NUM_CHANNELS; g++) begin : g_lane
    syzygy_adc_lane_shift u_lane (
      .slow_clk (slow_clk),
      .reset    (reset),
      .lane_in  (lane_data[g*LANE_WIDTH +: LANE_WIDTH]),
      .slip     (slip_q),
      .aligned  (aligned_all[g*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  assign slip_legal = (bitslip_count <= 4'(SLIP_MAX));

  // Next-state, slip capture, error flag and realign counter.
  always_comb begin
    state_d         = state_q;
    settle_cnt_d    = settle_cnt_q;
    slip_d          = slip_q;
    align_error_d   = align_error_q;
    realign_count_d = realign_count_q;
    sample_out_d    = aligned_all;

    if (!frame_valid) begin
      state_d = IDLE;
    end else if (!slip_legal) begin
      align_error_d = 1'b1;
      state_d       = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          slip_d       = bitslip_count[2:0];
          settle_cnt_d = 2'(SETTLE_CYCLES);
          state_d      = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d = STREAM;
          end else begin
            settle_cnt_d = settle_cnt_q - 2'd1;
          end
        end
        STREAM: begin
          if (bitslip_count != {1'b0, slip_q}) begin
            slip_d       = bitslip_count[2:0];
            settle_cnt_d = 2'(SETTLE_CYCLES);
            state_d      = SETTLE;
            if (realign_count_q != '1) begin
              realign_count_d = realign_count_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, control and output registers.
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q         <= IDLE;
      settle_cnt_q    <= '0;
      slip_q          <= '0;
      align_error_q   <= 1'b0;
      realign_count_q <= '0;
      sample_out_q    <= '0;
    end else begin
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      slip_q          <= slip_d;
      align_error_q   <= align_error_d;
      realign_count_q <= realign_count_d;
      sample_out_q    <= sample_out_d;
    end
  end

  assign sample_out    = sample_out_q;
  assign sample_valid  = (state_q == STREAM);
  assign align_error   = align_error_q;
  assign realign_count = realign_count_q;

endmodule

// File: tb/tb_syzygy_adc_word_align.sv
// Bench for syzygy_adc_word_align: directed test-plan steps plus random
// traffic, checked every cycle against a behavioural reference model.
module tb_syzygy_adc_word_align;

  logic        slow_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [3:0]  bitslip_count = '0;
  logic [31:0] lane_data = '0;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic        align_error;
  logic [7:0]  realign_count;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int          cyc = 0;
  logic [31:0] m_curr = '0;
  logic [31:0] m_prev = '0;
  int          m_slip = 0;
  bit          m_locked = 0;
  int          m_vstart = 0;
  bit          m_valid = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  logic [31:0] m_sample = '0;

  logic [7:0]  lane0_hist [0:15];

  syzygy_adc_word_align #(.NUM_CHANNELS(2)) dut (
    .slow_clk      (slow_clk),
    .reset         (reset),
    .frame_valid   (frame_valid),
    .bitslip_count (bitslip_count),
    .lane_data     (lane_data),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .align_error   (align_error),
    .realign_count (realign_count)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic r, input logic fv, input logic [3:0] bs, input logic [31:0] ld);
    int w;
    reset = r;
    frame_valid = fv;
    bitslip_count = bs;
    lane_data = ld;
    @(posedge slow_clk);
    for (int l = 0; l < 4; l++) begin
      w = int'(m_prev[8*l +: 8]) * 256 + int'(m_curr[8*l +: 8]);
      m_sample[8*l +: 8] = 8'((w >> m_slip) % 256);
    end
    if (r) begin
      m_sample = '0;
      m_curr = '0;
      m_prev = '0;
      m_slip = 0;
      m_locked = 0;
      m_err = 0;
      m_cnt = 0;
    end else begin
      m_prev = m_curr;
      m_curr = ld;
      if (!fv) begin
        m_locked = 0;
      end else if (bs > 7) begin
        m_err = 1;
        m_locked = 0;
      end else if (!m_locked) begin
        m_locked = 1;
        m_slip = int'(bs);
        m_vstart = cyc + 3;
      end else if (m_valid && int'(bs) != m_slip) begin
        m_slip = int'(bs);
        if (m_cnt < 255) m_cnt++;
        m_vstart = cyc + 3;
      end
    end
    m_valid = m_locked && (cyc >= m_vstart);
    #1;
    chk("sample_out", sample_out, m_sample);
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("align_error", 32'(align_error), 32'(m_err));
    chk("realign_count", 32'(realign_count), 32'(m_cnt));
    cyc++;
  endtask

  initial begin
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] ld;
    logic [3:0]  bs;
    logic        fv;
    logic        r;
    p0 = 32'hA50F_A50F;
    p1 = 32'h5AF0_5AF0;

    // Reset state.
    step(1, 0, 0, 32'hFFFF_FFFF);
    step(1, 0, 0, 32'h1234_5678);
    chk("rst_sample", sample_out, 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_err", 32'(align_error), 32'h0);
    chk("rst_cnt", 32'(realign_count), 32'h0);
    step(0, 0, 0, 32'h0);

    // 1: basic shift with slip 3 and alternating patterns.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3, (i % 2 == 1) ? p1 : p0);
      if (i == 2) chk("t1_valid_pre", 32'(sample_valid), 32'h0);
      if (i == 3) begin
        chk("t1_valid_rise", 32'(sample_valid), 32'h1);
        chk("t1_first_sample", sample_out, 32'h5401_5401);
      end
      if (i == 4) chk("t1_a5_5a_sample", sample_out, 32'hABFE_ABFE);
    end

    // 2: zero slip, lane 0 of channel 0 passes straight through.
    step(0, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      lane0_hist[i] = 8'h12 + 8'(8'h22 * i);
      ld = $urandom;
      ld[15:8] = lane0_hist[i];
      step(0, 1, 0, ld);
      if (i >= 3) chk("t2_msb_passthru", 32'(sample_out[15:8]), 32'(lane0_hist[i-1]));
    end

    // 3: realign 3 -> 5 during STREAM.
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 1, 3, $urandom);
    chk("t3_streaming", 32'(sample_valid), 32'h1);
    chk("t3_cnt_before", 32'(realign_count), 32'h0);
    step(0, 1, 5, $urandom);
    chk("t3_low0", 32'(sample_valid), 32'h0);
    chk("t3_cnt_after", 32'(realign_count), 32'h1);
    step(0, 1, 5, p0);
    chk("t3_low1", 32'(sample_valid), 32'h0);
    step(0, 1, 5, p1);
    chk("t3_low2", 32'(sample_valid), 32'h0);
    step(0, 1, 5, $urandom);
    chk("t3_valid_back", 32'(sample_valid), 32'h1);
    chk("t3_slip5_sample", sample_out, 32'h2A7F_2A7F);

    // 4: illegal slip value, then recovery with a sticky error.
    step(0, 1, 9, $urandom);
    chk("t4_err_set", 32'(align_error), 32'h1);
    chk("t4_valid_low", 32'(sample_valid), 32'h0);
    step(0, 1, 9, $urandom);
    step(0, 1, 12, $urandom);
    chk("t4_still_idle", 32'(sample_valid), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 2, $urandom);
    chk("t4_resumed", 32'(sample_valid), 32'h1);
    chk("t4_err_sticky", 32'(align_error), 32'h1);

    // 5: frame_valid fall beats a simultaneous slip change.
    step(0, 0, 6, $urandom);
    chk("t5_valid_low", 32'(sample_valid), 32'h0);
    chk("t5_cnt_same", 32'(realign_count), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 6, $urandom);
    chk("t5_relock_nocount", 32'(realign_count), 32'h1);

    // 6a: reset mid-STREAM.
    step(1, 1, 6, $urandom);
    chk("t6_rst_sample", sample_out, 32'h0);
    chk("t6_rst_valid", 32'(sample_valid), 32'h0);
    chk("t6_rst_err", 32'(align_error), 32'h0);
    chk("t6_rst_cnt", 32'(realign_count), 32'h0);

    // 6b: 300 slip changes saturate the realign counter.
    for (int i = 0; i < 4; i++) step(0, 1, 1, $urandom);
    for (int k = 0; k < 300; k++) begin
      bs = (k % 2 == 0) ? 4'd6 : 4'd1;
      for (int j = 0; j < 4; j++) step(0, 1, bs, $urandom);
    end
    chk("t6_cnt_saturated", 32'(realign_count), 32'd255);

    // Random traffic.
    bs = 4'd4;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      fv = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bs = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      end
      step(r, fv, bs, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
